dmem_access_unit: RTL and testbench

- Responder side of the core's mem_read/mem_write load/store requests.
- Sits between the MEM stage and the data memory/MMIO bus.
- Accepts one load or store at a time and generates byte-lane write enables and replicated store data.
- Handles a wait-stated memory handshake, then returns aligned, sign- or zero-extended load data while stalling the pipeline.

---
 rtl/dmem_access_unit_if.sv | 44 ++++
 rtl/dmem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: request/response and memory-bus signals of the
// data memory access unit.
// The slave modport is the access unit's view.
// The master modport is the view of the surrounding core/memory.
interface dmem_access_unit_if #(
    parameter int AWIDTH = 32
);
    // MEM stage request side
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AWIDTH-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_funct3;

    // Pipeline control and completion
    logic              stall;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    // Data memory / MMIO bus
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [AWIDTH-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, stall, resp_valid, resp_rdata, resp_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, stall, resp_valid, resp_rdata, resp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: accepts one load/store from the MEM stage at a time.
// It drives a wait-stated memory handshake and builds byte-lane write
// enables and lane-replicated store data. Load data is returned aligned
// and sign/zero extended, and the pipeline is stalled until completion.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned halfword/word requests
// skip the memory and complete immediately with resp_err=1.
module dmem_access_unit #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_access_unit_if.slave    bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic              we_q,        we_d;
    logic [AWIDTH-1:0] addr_q,      addr_d;
    logic [DWIDTH-1:0] wdata_q,     wdata_d;
    logic [3:0]        mask_q,      mask_d;
    logic [2:0]        funct3_q,    funct3_d;
    logic [DWIDTH-1:0] rdata_q,     rdata_d;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic              err_q,       err_d;
    logic              misaligned;
`endif

    logic [3:0]        storeMask;
    logic [DWIDTH-1:0] storeData;
    logic [DWIDTH-1:0] loadData;
    logic [DWIDTH-1:0] shiftedWord;
    logic [7:0]        loadByte;
    logic [15:0]       loadHalf;
    logic              extBit;

    // Store lane mask and replicated data from the incoming request;
    // funct3[1:0] gives the size, reserved encodings fall back to word.
    always_comb begin
        storeMask = 4'b1111;
        storeData = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                storeMask = 4'b0001 << bus.req_addr[1:0];
                storeData = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                storeMask = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                storeData = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                storeMask = 4'b1111;
                storeData = bus.req_wdata;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Halfword needs addr[0]=0, word (including reserved sizes) needs addr[1:0]=0.
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bus.req_addr[0];
            default: misaligned = (bus.req_addr[1:0] != 2'b00);
        endcase
    end
`endif

    // Pick the addressed byte/halfword out of the raw read word and extend
    // it; funct3[2] selects zero extension for the unsigned loads.
    always_comb begin
        shiftedWord = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        loadByte    = shiftedWord[7:0];
        loadHalf    = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        extBit      = 1'b0;
        loadData    = bus.mem_rdata;
        case (funct3_q[1:0])
            2'b00: begin
                extBit   = ~funct3_q[2] & loadByte[7];
                loadData = {{24{extBit}}, loadByte};
            end
            2'b01: begin
                extBit   = ~funct3_q[2] & loadHalf[15];
                loadData = {{16{extBit}}, loadHalf};
            end
            default: begin
                extBit   = 1'b0;
                loadData = bus.mem_rdata;
            end
        endcase
    end

    // Next-state logic: capture the request in IDLE, wait for acceptance in
    // ISSUE, wait for read data in WAIT_RD, and give a single RESP cycle.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        funct3_d = funct3_q;
        rdata_d  = rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_we ? storeData : '0;
                    mask_d   = bus.req_we ? storeMask : 4'b0000;
                    funct3_d = bus.req_funct3;
                    rdata_d  = '0;
`ifdef DMEM_MISALIGN_TRAP_EN
                    err_d    = misaligned;
                    state_d  = misaligned ? RESP : ISSUE;
`else
                    state_d  = ISSUE;
`endif
                end
            end
            ISSUE: begin
                if (bus.mem_ready) begin
                    state_d = we_q ? RESP : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (bus.mem_rvalid) begin
                    rdata_d = loadData;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= 4'b0000;
            funct3_q <= 3'b000;
            rdata_q  <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            funct3_q <= funct3_d;
            rdata_q  <= rdata_d;
`ifdef DMEM_MISALIGN_TRAP_EN
            err_q    <= err_d;
`endif
        end
    end

    // Output decode; memory command fields come straight from the
    // registers so they stay stable while ISSUE waits for mem_ready.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.stall      = ((state_q == IDLE) & bus.req_valid)
                       | (state_q == ISSUE) | (state_q == WAIT_RD);
        bus.resp_valid = (state_q == RESP);
        bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;
`ifdef DMEM_MISALIGN_TRAP_EN
        bus.resp_err   = (state_q == RESP) & err_q;
`else
        bus.resp_err   = 1'b0;
`endif
        bus.mem_en     = (state_q == ISSUE);
        bus.mem_we     = (state_q == ISSUE) ? mask_q : 4'b0000;
        bus.mem_addr   = addr_q[AWIDTH-1:2];
        bus.mem_wdata  = wdata_q;
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed scenario tests for dmem_access_unit with
// hand-computed expected values.
module tb_dmem_access_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dmem_access_unit_if #(.AWIDTH(32)) bus ();

    dmem_access_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] f3);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_funct3 = f3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_req_ready: got %b expected 1", bus.req_ready); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall: got %b expected 0", bus.stall); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_resp_valid: got %b expected 0", bus.resp_valid); end
        total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_resp_rdata: got %h expected 0", bus.resp_rdata); end
        total++; if (bus.resp_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_resp_err: got %b expected 0", bus.resp_err); end
        total++; if (bus.mem_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_en: got %b expected 0", bus.mem_en); end
        total++; if (bus.mem_we !== 4'b0000) begin bad++; $display("[TB] FAIL rst_mem_we: got %b expected 0000", bus.mem_we); end
        total++; if (bus.mem_addr !== 30'h0) begin bad++; $display("[TB] FAIL rst_mem_addr: got %h expected 0", bus.mem_addr); end
        total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_mem_wdata: got %h expected 0", bus.mem_wdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_midop();
        bus.mem_ready = 1'b1;
        applyStimulus(1'b0, 32'h0000_2002, 32'h0, 3'b010);
        tick();
        bus.req_valid = 1'b0;
        tick();
        total++; if (bus.stall !== 1'b1) begin bad++; $display("[TB] FAIL midrst_waitrd_stall: got %b expected 1", bus.stall); end
        rst = 1'b1;
        tick();
        total++; if (bus.mem_en !== 1'b0) begin bad++; $display("[TB] FAIL midrst_mem_en: got %b expected 0", bus.mem_en); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_req_ready: got %b expected 1", bus.req_ready); end
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_resp_valid[%0d]: got %b expected 0", i, bus.resp_valid); end
            total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_idle[%0d]: got %b expected 1", i, bus.req_ready); end
            total++; if (bus.mem_en !== 1'b0) begin bad++; $display("[TB] FAIL midrst_mem_en[%0d]: got %b expected 0", i, bus.mem_en); end
            tick();
        end
    endtask

    // Store vectors: SB 0x1003, SH 0x1002, reserved funct3 011 as word
    task automatic test_store();
        logic [31:0] vAddr [3];
        logic [31:0] vData [3];
        logic [2:0]  vF3   [3];
        logic [3:0]  eMask [3];
        logic [31:0] eData [3];
        vAddr[0] = 32'h0000_1003; vData[0] = 32'hAABB_CCDD; vF3[0] = 3'b000; eMask[0] = 4'b1000; eData[0] = 32'hDDDD_DDDD;
        vAddr[1] = 32'h0000_1002; vData[1] = 32'h1234_BEEF; vF3[1] = 3'b001; eMask[1] = 4'b1100; eData[1] = 32'hBEEF_BEEF;
        vAddr[2] = 32'h0000_1000; vData[2] = 32'h0102_0304; vF3[2] = 3'b011; eMask[2] = 4'b1111; eData[2] = 32'h0102_0304;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, vAddr[i], vData[i], vF3[i]);
            #1;
            total++; if (bus.stall !== 1'b1) begin bad++; $display("[TB] FAIL st%0d_idle_stall: got %b expected 1", i, bus.stall); end
            tick();
            bus.req_valid = 1'b0;
            total++; if (bus.mem_en !== 1'b1) begin bad++; $display("[TB] FAIL st%0d_mem_en: got %b expected 1", i, bus.mem_en); end
            total++; if (bus.mem_we !== eMask[i]) begin bad++; $display("[TB] FAIL st%0d_mem_we: got %b expected %b", i, bus.mem_we, eMask[i]); end
            total++; if (bus.mem_wdata !== eData[i]) begin bad++; $display("[TB] FAIL st%0d_mem_wdata: got %h expected %h", i, bus.mem_wdata, eData[i]); end
            total++; if (bus.mem_addr !== 30'h400) begin bad++; $display("[TB] FAIL st%0d_mem_addr: got %h expected 400", i, bus.mem_addr); end
            total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL st%0d_early_resp: got %b expected 0", i, bus.resp_valid); end
            tick();
            total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL st%0d_resp_valid: got %b expected 1", i, bus.resp_valid); end
            total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL st%0d_resp_rdata: got %h expected 0", i, bus.resp_rdata); end
            total++; if (bus.stall !== 1'b0) begin bad++; $display("[TB] FAIL st%0d_resp_stall: got %b expected 0", i, bus.stall); end
            total++; if (bus.mem_en !== 1'b0) begin bad++; $display("[TB] FAIL st%0d_resp_mem_en: got %b expected 0", i, bus.mem_en); end
            tick();
            total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL st%0d_resp_pulse: got %b expected 0", i, bus.resp_valid); end
        end
    endtask

    // Load vectors over raw words 0x12F45678 / 0x80010000
    task automatic test_load();
        logic [31:0] vAddr [6];
        logic [2:0]  vF3   [6];
        logic [31:0] vRaw  [6];
        logic [31:0] eData [6];
        vAddr[0] = 32'h0000_2002; vF3[0] = 3'b000; vRaw[0] = 32'h12F4_5678; eData[0] = 32'hFFFF_FFF4;
        vAddr[1] = 32'h0000_2002; vF3[1] = 3'b100; vRaw[1] = 32'h12F4_5678; eData[1] = 32'h0000_00F4;
        vAddr[2] = 32'h0000_2000; vF3[2] = 3'b001; vRaw[2] = 32'h12F4_5678; eData[2] = 32'h0000_5678;
        vAddr[3] = 32'h0000_2002; vF3[3] = 3'b101; vRaw[3] = 32'h8001_0000; eData[3] = 32'h0000_8001;
        vAddr[4] = 32'h0000_2000; vF3[4] = 3'b010; vRaw[4] = 32'h8001_0000; eData[4] = 32'h8001_0000;
        vAddr[5] = 32'h0000_2000; vF3[5] = 3'b110; vRaw[5] = 32'h12F4_5678; eData[5] = 32'h12F4_5678;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, vAddr[i], 32'hFFFF_FFFF, vF3[i]);
            tick();
            bus.req_valid = 1'b0;
            total++; if (bus.mem_en !== 1'b1) begin bad++; $display("[TB] FAIL ld%0d_mem_en: got %b expected 1", i, bus.mem_en); end
            total++; if (bus.mem_we !== 4'b0000) begin bad++; $display("[TB] FAIL ld%0d_mem_we: got %b expected 0000", i, bus.mem_we); end
            total++; if (bus.mem_addr !== 30'h800) begin bad++; $display("[TB] FAIL ld%0d_mem_addr: got %h expected 800", i, bus.mem_addr); end
            tick();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = vRaw[i];
            total++; if (bus.mem_en !== 1'b0) begin bad++; $display("[TB] FAIL ld%0d_waitrd_mem_en: got %b expected 0", i, bus.mem_en); end
            total++; if (bus.stall !== 1'b1) begin bad++; $display("[TB] FAIL ld%0d_waitrd_stall: got %b expected 1", i, bus.stall); end
            tick();
            bus.mem_rvalid = 1'b0;
            total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL ld%0d_resp_valid: got %b expected 1", i, bus.resp_valid); end
            total++; if (bus.resp_rdata !== eData[i]) begin bad++; $display("[TB] FAIL ld%0d_resp_rdata: got %h expected %h", i, bus.resp_rdata, eData[i]); end
            tick();
        end
    endtask

    task automatic test_wait_states();
        bus.mem_ready = 1'b0;
        applyStimulus(1'b0, 32'h0000_2002, 32'h0, 3'b001);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.mem_en !== 1'b1) begin bad++; $display("[TB] FAIL ws_mem_en[%0d]: got %b expected 1", i, bus.mem_en); end
            total++; if (bus.mem_addr !== 30'h800) begin bad++; $display("[TB] FAIL ws_mem_addr[%0d]: got %h expected 800", i, bus.mem_addr); end
            total++; if (bus.stall !== 1'b1) begin bad++; $display("[TB] FAIL ws_issue_stall[%0d]: got %b expected 1", i, bus.stall); end
            // rvalid during ISSUE must be ignored
            bus.mem_rvalid = (i == 1);
            bus.mem_rdata  = 32'h0000_0000;
            tick();
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_ready  = 1'b1;
        total++; if (bus.mem_en !== 1'b1) begin bad++; $display("[TB] FAIL ws_accept_mem_en: got %b expected 1", bus.mem_en); end
        tick();
        bus.mem_ready = 1'b0;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("[TB] FAIL ws_waitrd1_stall: got %b expected 1", bus.stall); end
        tick();
        total++; if (bus.stall !== 1'b1) begin bad++; $display("[TB] FAIL ws_waitrd2_stall: got %b expected 1", bus.stall); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL ws_waitrd_resp: got %b expected 0", bus.resp_valid); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h8001_0000;
        tick();
        bus.mem_rvalid = 1'b0;
        total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL ws_resp_valid: got %b expected 1", bus.resp_valid); end
        total++; if (bus.resp_rdata !== 32'hFFFF_8001) begin bad++; $display("[TB] FAIL ws_resp_rdata: got %h expected ffff8001", bus.resp_rdata); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("[TB] FAIL ws_resp_stall: got %b expected 0", bus.stall); end
        tick();
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int respCount;
        respCount = 0;
        bus.mem_ready = 1'b1;
        applyStimulus(1'b1, 32'h0000_3000, 32'h1122_3344, 3'b010);
        tick();
        // SW accepted; the LW is now presented and held
        applyStimulus(1'b0, 32'h0000_3000, 32'h0, 3'b010);
        total++; if (bus.mem_we !== 4'b1111) begin bad++; $display("[TB] FAIL b2b_sw_mem_we: got %b expected 1111", bus.mem_we); end
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_issue_ready: got %b expected 0", bus.req_ready); end
        tick();
        if (bus.resp_valid === 1'b1) respCount++;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_resp_ready: got %b expected 0", bus.req_ready); end
        total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_sw_resp: got %b expected 1", bus.resp_valid); end
        tick();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_idle_ready: got %b expected 1", bus.req_ready); end
        total++; if (bus.stall !== 1'b1) begin bad++; $display("[TB] FAIL b2b_idle_stall: got %b expected 1", bus.stall); end
        total++; if (bus.mem_en !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle_mem_en: got %b expected 0", bus.mem_en); end
        tick();
        bus.req_valid = 1'b0;
        total++; if (bus.mem_en !== 1'b1) begin bad++; $display("[TB] FAIL b2b_lw_mem_en: got %b expected 1", bus.mem_en); end
        total++; if (bus.mem_we !== 4'b0000) begin bad++; $display("[TB] FAIL b2b_lw_mem_we: got %b expected 0000", bus.mem_we); end
        total++; if (bus.mem_addr !== 30'hC00) begin bad++; $display("[TB] FAIL b2b_lw_mem_addr: got %h expected c00", bus.mem_addr); end
        bus.mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 6; i++) begin
            bus.mem_rvalid = 1'b1;
            tick();
            if (bus.resp_valid === 1'b1) begin
                respCount++;
                total++; if (bus.resp_rdata !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL b2b_lw_rdata: got %h expected cafef00d", bus.resp_rdata); end
            end
        end
        bus.mem_rvalid = 1'b0;
        total++; if (respCount !== 2) begin bad++; $display("[TB] FAIL b2b_resp_count: got %0d expected 2", respCount); end
        tick();
    endtask

`ifdef DMEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        bus.mem_ready = 1'b1;
        applyStimulus(1'b0, 32'h0000_3002, 32'h0, 3'b010);
        #1;
        total++; if (bus.mem_en !== 1'b0) begin bad++; $display("[TB] FAIL mis_accept_mem_en: got %b expected 0", bus.mem_en); end
        tick();
        bus.req_valid = 1'b0;
        total++; if (bus.mem_en !== 1'b0) begin bad++; $display("[TB] FAIL mis_mem_en: got %b expected 0", bus.mem_en); end
        total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL mis_resp_valid: got %b expected 1", bus.resp_valid); end
        total++; if (bus.resp_err !== 1'b1) begin bad++; $display("[TB] FAIL mis_resp_err: got %b expected 1", bus.resp_err); end
        total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL mis_resp_rdata: got %h expected 0", bus.resp_rdata); end
        tick();
        total++; if (bus.resp_err !== 1'b0) begin bad++; $display("[TB] FAIL mis_err_pulse: got %b expected 0", bus.resp_err); end
    endtask
`else
    task automatic test_misalign();
        bus.mem_ready = 1'b1;
        applyStimulus(1'b0, 32'h0000_3002, 32'h0, 3'b010);
        tick();
        bus.req_valid = 1'b0;
        total++; if (bus.mem_en !== 1'b1) begin bad++; $display("[TB] FAIL mis_mem_en: got %b expected 1", bus.mem_en); end
        total++; if (bus.mem_addr !== 30'hC00) begin bad++; $display("[TB] FAIL mis_mem_addr: got %h expected c00", bus.mem_addr); end
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hA5A5_1234;
        tick();
        bus.mem_rvalid = 1'b0;
        total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL mis_resp_valid: got %b expected 1", bus.resp_valid); end
        total++; if (bus.resp_err !== 1'b0) begin bad++; $display("[TB] FAIL mis_resp_err: got %b expected 0", bus.resp_err); end
        total++; if (bus.resp_rdata !== 32'hA5A5_1234) begin bad++; $display("[TB] FAIL mis_resp_rdata: got %h expected a5a51234", bus.resp_rdata); end
        tick();
    endtask
`endif

    // Scenario sequence
    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_funct3 = 3'b000;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        test_reset();
        test_reset_midop();
        test_store();
        test_load();
        test_wait_states();
        test_back_to_back();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
